// File: rtl/pc_seq_unit.sv
// Program counter sequencer with INC/LOAD/REL/CALL/RET modes and a return-address stack.
// Stack faults and illegal modes leave PC and stack untouched and raise a sticky STK_err.
module pc_seq_unit #(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   RESET_VEC = 16'h0010,
  parameter int                 STEP      = 1,
  parameter int                 OFS_W     = 8,
  parameter int                 DEPTH     = 8,
  localparam int                CW        = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PC_en,
  input  logic [2:0]       PC_mode,
  input  logic [WIDTH-1:0] PC_IN,
  input  logic [OFS_W-1:0] OFFSET,
  input  logic             ERR_clr,
  output logic [WIDTH-1:0] PC_OUT,
  output logic [CW-1:0]    STK_cnt,
  output logic             STK_full,
  output logic             STK_empty,
  output logic             STK_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] MODE_INC  = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_REL  = 3'b010;
  localparam logic [2:0] MODE_CALL = 3'b011;
  localparam logic [2:0] MODE_RET  = 3'b100;

  // Contents are never reset: STK_cnt alone defines which entries are valid.
  logic [WIDTH-1:0] stack [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_rel;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] pc_next;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_m1;
  logic             do_push;
  logic             err_event;

  assign STK_full  = (STK_cnt == CW'(DEPTH));
  assign STK_empty = (STK_cnt == '0);

  assign pc_inc  = PC_OUT + WIDTH'(STEP);
  assign pc_rel  = PC_OUT + WIDTH'($signed(OFFSET));
  assign cnt_m1  = STK_cnt - CW'(1);
  assign top_val = stack[cnt_m1[IW-1:0]];

  always_comb begin
    pc_next   = PC_OUT;
    cnt_next  = STK_cnt;
    do_push   = 1'b0;
    err_event = 1'b0;
    if (PC_en) begin
      case (PC_mode)
        MODE_INC:  pc_next = pc_inc;
        MODE_LOAD: pc_next = PC_IN;
        MODE_REL:  pc_next = pc_rel;
        MODE_CALL: begin
          if (STK_full) begin
            err_event = 1'b1;
          end else begin
            do_push  = 1'b1;
            pc_next  = PC_IN;
            cnt_next = STK_cnt + CW'(1);
          end
        end
        MODE_RET: begin
          if (STK_empty) begin
            err_event = 1'b1;
          end else begin
            pc_next  = top_val;
            cnt_next = cnt_m1;
          end
        end
        default: err_event = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC_OUT  <= RESET_VEC;
      STK_cnt <= '0;
      STK_err <= 1'b0;
    end else begin
      PC_OUT  <= pc_next;
      STK_cnt <= cnt_next;
      // A new fault wins over a simultaneous clear.
      if (err_event) STK_err <= 1'b1;
      else if (ERR_clr) STK_err <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !RST) stack[STK_cnt[IW-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed vector table, hand sequences for
// stack overflow/underflow and mid-cycle reset, then random stimulus against a queue model.
module tb_pc_seq_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PC_en = 1'b0;
  logic [2:0]  PC_mode = 3'b000;
  logic [15:0] PC_IN = '0;
  logic [7:0]  OFFSET = '0;
  logic        ERR_clr = 1'b0;
  logic [15:0] PC_OUT;
  logic [3:0]  STK_cnt;
  logic        STK_full;
  logic        STK_empty;
  logic        STK_err;

  pc_seq_unit dut (
    .CLK(CLK), .RST(RST), .PC_en(PC_en), .PC_mode(PC_mode), .PC_IN(PC_IN),
    .OFFSET(OFFSET), .ERR_clr(ERR_clr), .PC_OUT(PC_OUT), .STK_cnt(STK_cnt),
    .STK_full(STK_full), .STK_empty(STK_empty), .STK_err(STK_err)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  // behavioural model: plain arithmetic plus a queue for the return stack
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_err;
  logic [15:0] exp_q[$];

  task automatic model_reset();
    m_pc = 16'h0010;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_apply(input logic en, input logic [2:0] mode, input logic [15:0] pin,
                             input logic [7:0] ofs, input logic clr);
    logic ev;
    ev = 1'b0;
    if (en) begin
      case (mode)
        3'd0: m_pc = m_pc + 16'd1;
        3'd1: m_pc = pin;
        3'd2: m_pc = m_pc + {{8{ofs[7]}}, ofs};
        3'd3: if (m_stk.size() == 8) ev = 1'b1;
              else begin m_stk.push_back(m_pc + 16'd1); m_pc = pin; end
        3'd4: if (m_stk.size() == 0) ev = 1'b1;
              else m_pc = m_stk.pop_back();
        default: ev = 1'b1;
      endcase
    end
    m_err = ev | (m_err & ~clr);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string name, input logic [15:0] pc, input int cnt, input logic err);
    chk({name, ".pc"}, 32'(PC_OUT), 32'(pc));
    chk({name, ".cnt"}, 32'(STK_cnt), 32'(cnt));
    chk({name, ".full"}, 32'(STK_full), 32'(cnt == 8));
    chk({name, ".empty"}, 32'(STK_empty), 32'(cnt == 0));
    chk({name, ".err"}, 32'(STK_err), 32'(err));
  endtask

  // driver: inputs change 1 time unit after an edge, outputs sampled 1 unit after the next
  task automatic step(input logic en, input logic [2:0] mode, input logic [15:0] pin,
                      input logic [7:0] ofs, input logic clr);
    PC_en = en; PC_mode = mode; PC_IN = pin; OFFSET = ofs; ERR_clr = clr;
    @(posedge CLK);
    #1;
    if (!RST) model_apply(en, mode, pin, ofs, clr);
  endtask

  typedef struct {
    logic        en;
    logic [2:0]  mode;
    logic [15:0] pin;
    logic [7:0]  ofs;
    logic        clr;
    logic [15:0] pc;
    int          cnt;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic [2:0] mode, input logic [15:0] pin,
                     input logic [7:0] ofs, input logic clr, input logic [15:0] pc,
                     input int cnt, input logic err);
    vec_t v;
    v.en = en; v.mode = mode; v.pin = pin; v.ofs = ofs; v.clr = clr;
    v.pc = pc; v.cnt = cnt; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] ret_addr [8];
    logic [15:0] pc_before;
    logic [15:0] exp_pc;

    // en, mode, pin, ofs, clr -> pc, cnt, err
    add(1, 3'd0, 16'h0000, 8'h00, 0, 16'h0011, 0, 0);
    add(1, 3'd0, 16'h0000, 8'h00, 0, 16'h0012, 0, 0);
    add(1, 3'd0, 16'h0000, 8'h00, 0, 16'h0013, 0, 0);
    add(0, 3'd0, 16'h0000, 8'h00, 0, 16'h0013, 0, 0);
    add(0, 3'd3, 16'h0500, 8'h00, 0, 16'h0013, 0, 0);
    add(1, 3'd1, 16'h0020, 8'h00, 0, 16'h0020, 0, 0);
    add(1, 3'd2, 16'h0000, 8'hF0, 0, 16'h0010, 0, 0);
    add(1, 3'd1, 16'hFFFF, 8'h00, 0, 16'hFFFF, 0, 0);
    add(1, 3'd0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0);
    add(1, 3'd1, 16'hFFF0, 8'h00, 0, 16'hFFF0, 0, 0);
    add(1, 3'd2, 16'h0000, 8'h7F, 0, 16'h006F, 0, 0);
    add(1, 3'd1, 16'h0040, 8'h00, 0, 16'h0040, 0, 0);
    add(1, 3'd3, 16'h0100, 8'h00, 0, 16'h0100, 1, 0);
    add(1, 3'd3, 16'h0200, 8'h00, 0, 16'h0200, 2, 0);
    add(1, 3'd4, 16'h0000, 8'h00, 0, 16'h0101, 1, 0);
    add(1, 3'd4, 16'h0000, 8'h00, 0, 16'h0041, 0, 0);
    add(1, 3'd4, 16'h0000, 8'h00, 0, 16'h0041, 0, 1);
    add(1, 3'd0, 16'h0000, 8'h00, 1, 16'h0042, 0, 0);
    add(1, 3'd6, 16'h1234, 8'h00, 0, 16'h0042, 0, 1);
    add(1, 3'd0, 16'h0000, 8'h00, 1, 16'h0043, 0, 0);
    add(1, 3'd4, 16'h0000, 8'h00, 1, 16'h0043, 0, 1);
    add(0, 3'd7, 16'h0000, 8'h00, 1, 16'h0043, 0, 0);

    // reset with no clock edge: first rising edge is at t=5
    #1 RST = 1'b1;
    #2;
    model_reset();
    chk_state("async_reset", 16'h0010, 0, 0);
    PC_en = 1'b1; PC_mode = 3'd1; PC_IN = 16'hBEEF;
    @(posedge CLK); #1;
    chk_state("reset_ignores_en", 16'h0010, 0, 0);
    RST = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].mode, vecs[i].pin, vecs[i].ofs, vecs[i].clr);
      chk_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].cnt, vecs[i].err);
    end

    // fill the stack, overflow, clear, then drain in reverse order
    step(1, 3'd1, 16'h0300, 8'h00, 0);
    pc_before = 16'h0300;
    for (int k = 0; k < 8; k++) begin
      ret_addr[k] = pc_before + 16'd1;
      step(1, 3'd3, 16'h1000 + 16'(k) * 16'h0100, 8'h00, 0);
      pc_before = 16'h1000 + 16'(k) * 16'h0100;
      chk_state($sformatf("fill%0d", k), pc_before, k + 1, 0);
    end
    step(1, 3'd3, 16'hABCD, 8'h00, 0);
    chk_state("overflow", 16'h1700, 8, 1);
    step(0, 3'd0, 16'h0000, 8'h00, 1);
    chk_state("err_clr", 16'h1700, 8, 0);
    for (int k = 7; k >= 0; k--) begin
      step(1, 3'd4, 16'h0000, 8'h00, 0);
      chk_state($sformatf("drain%0d", k), ret_addr[k], k, 0);
    end

    // reset asserted between edges while a CALL is being presented
    for (int k = 0; k < 3; k++) step(1, 3'd3, 16'h2000 + 16'(k), 8'h00, 0);
    chk_state("pre_reset", 16'h2002, 3, 0);
    PC_en = 1'b1; PC_mode = 3'd3; PC_IN = 16'h3000;
    #3 RST = 1'b1;
    #1;
    model_reset();
    chk_state("mid_reset", 16'h0010, 0, 0);
    @(posedge CLK); #1;
    chk_state("mid_reset_hold", 16'h0010, 0, 0);
    RST = 1'b0;
    step(1, 3'd4, 16'h0000, 8'h00, 0);
    chk_state("ret_after_reset", 16'h0010, 0, 1);

    // random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      logic        en;
      logic [2:0]  mode;
      int          r;
      en = ($urandom_range(0, 9) != 0);
      r  = $urandom_range(0, 19);
      if (r < 4) mode = 3'd0;
      else if (r < 6) mode = 3'd1;
      else if (r < 9) mode = 3'd2;
      else if (r < 14) mode = 3'd3;
      else if (r < 19) mode = 3'd4;
      else mode = 3'($urandom_range(5, 7));
      step(en, mode, 16'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
      exp_q.push_back(m_pc);
      exp_pc = exp_q.pop_front();
      chk_state($sformatf("rnd%0d", n), exp_pc, m_stk.size(), m_err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
